// File: rtl/ifu_fetch_pkg.sv
// Fetch stage shared definitions: widths, FSM encodings,
// the instruction queue entry layout and an alignment helper.
package ifu_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INSTR_SIZE = 32;

    localparam logic [1:0] IFU_IDLE  = 2'd0;
    localparam logic [1:0] IFU_FETCH = 2'd1;
    localparam logic [1:0] IFU_HALT  = 2'd2;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [XLEN-1:0]       pc;
        logic                  err;
    } ir_entry_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory channel: valid/ready request, always-accepted
// in-order response. master = fetch stage, slave = memory.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [XLEN-1:0]       ifu_req_addr;
    logic                  ifu_rsp_valid;
    logic [INSTR_SIZE-1:0] ifu_rsp_instr;
    logic                  ifu_rsp_err;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_instr,
        input  ifu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_instr,
        output ifu_rsp_err
    );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head is read directly from storage.
// Push on a full FIFO is legal only together with a pop.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = ram[rd_ptr];

    // Storage write; zeroed on reset so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (push_ok && !flush) begin
            ram[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word requests,
// queues returned words for decode and restarts on redirect.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    ifu_fetch_if.master           mem,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [INSTR_SIZE-1:0] ir_instr,
    output logic [XLEN-1:0]       ir_pc,
    output logic                  ir_err
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop;

    logic            req_hs;
    logic            rsp_ok;
    logic            q_push;
    logic            q_pop;
    logic [CW:0]     credit_use;

    logic [XLEN-1:0] a_head;
    logic            a_full;
    logic            a_empty;
    logic [CW-1:0]   a_cnt;

    ir_entry_t       q_din;
    ir_entry_t       q_dout;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_cnt;

    // A head leaving this cycle frees its slot for a new request,
    // which keeps a 1-cycle memory streaming at one word per cycle.
    assign q_pop      = ir_valid && ir_ready;
    assign credit_use = {1'b0, a_cnt} + {1'b0, q_cnt}
                      - (CW+1)'(q_pop);

    assign mem.ifu_req_valid = (state == IFU_FETCH) && !a_full
                             && (credit_use < QLIM);
    assign mem.ifu_req_addr  = pc;

    assign req_hs = mem.ifu_req_valid && mem.ifu_req_ready;
    assign rsp_ok = mem.ifu_rsp_valid && !a_empty;
    assign q_push = rsp_ok && (drop == '0) && !redirect_valid
                  && (!q_full || q_pop);

    assign q_din = '{instr: mem.ifu_rsp_instr,
                     pc:    a_head,
                     err:   mem.ifu_rsp_err};

    assign ir_valid = !q_empty;
    assign ir_instr = q_dout.instr;
    assign ir_pc    = q_dout.pc;
    assign ir_err   = q_dout.err;

    // PC: redirect target, else advance on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (req_hs) begin
            pc <= pc + XLEN'(4);
        end
    end

    // Stale-word counter: everything in flight at a redirect is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= '0;
        end else if (redirect_valid) begin
            drop <= a_cnt + CW'(req_hs) - CW'(rsp_ok);
        end else if (rsp_ok && drop != '0) begin
            drop <= drop - CW'(1);
        end
    end

    // Control FSM: start after reset, stop on a queued bus error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IFU_IDLE;
        end else if (redirect_valid) begin
            state <= IFU_FETCH;
        end else begin
            unique case (1'b1)
                (state == IFU_IDLE):
                    state <= IFU_FETCH;
                (state == IFU_FETCH && q_push && mem.ifu_rsp_err):
                    state <= IFU_HALT;
                default:
                    state <= state;
            endcase
        end
    end

    ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_addr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_hs),
        .din   (pc),
        .pop   (rsp_ok),
        .flush (1'b0),
        .dout  (a_head),
        .full  (a_full),
        .empty (a_empty),
        .count (a_cnt)
    );

    ifu_fifo #(
        .WIDTH ($bits(ir_entry_t)),
        .DEPTH (QDEPTH)
    ) u_ir_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .flush (redirect_valid),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: in-order memory model, directed sequences,
// a redirect table and a randomized run against a stream model.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  ir_valid;
    logic                  ir_ready;
    logic [INSTR_SIZE-1:0] ir_instr;
    logic [XLEN-1:0]       ir_pc;
    logic                  ir_err;

    ifu_fetch_if mem ();

    ifu_fetch #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem            (mem),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc),
        .ir_err         (ir_err)
    );

    int n_chk, n_pass;

    // knobs
    int p_rdy, p_ir, lat_lo, lat_hi;
    logic redir_req;
    logic [31:0] redir_tgt;
    logic err_en;
    logic [31:0] err_addr;

    // memory model
    logic [31:0] mq_addr[$];
    int mq_due[$];
    int mq_ep[$];

    // reference model of the decode-side stream and request stream
    int cyc, epoch;
    logic [31:0] exp_pc, req_exp, after_tgt;
    bit halted, after_redir;
    int n_ir, n_req;
    logic [31:0] ir_log[$];
    bit saw_err;
    logic [31:0] err_pc;

    // samples
    logic s_req_valid, s_ir_valid, s_hs, s_rsp;
    logic [31:0] s_req_addr, s_ir_pc;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function void chk(input string name, input logic [95:0] act,
                      input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    task automatic cycle();
        logic hs;
        redirect_valid    = redir_req;
        redirect_pc       = redir_tgt;
        mem.ifu_req_ready = ($urandom_range(99) < p_rdy);
        ir_ready          = ($urandom_range(99) < p_ir);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem.ifu_rsp_valid = 1'b1;
            mem.ifu_rsp_instr = instr_of(mq_addr[0]);
            mem.ifu_rsp_err   = err_en && (mq_addr[0] == err_addr);
        end else begin
            mem.ifu_rsp_valid = 1'b0;
            mem.ifu_rsp_instr = '0;
            mem.ifu_rsp_err   = 1'b0;
        end
        @(negedge clk);
        hs = mem.ifu_req_valid && mem.ifu_req_ready;
        s_req_valid = mem.ifu_req_valid;
        s_req_addr  = mem.ifu_req_addr;
        s_ir_valid  = ir_valid;
        s_ir_pc     = ir_pc;
        s_hs        = hs;
        s_rsp       = mem.ifu_rsp_valid;
        if (after_redir) begin
            chk("redir_addr", mem.ifu_req_addr, after_tgt);
            chk("redir_irv", ir_valid, 0);
        end
        if (ir_valid && ir_ready) begin
            chk("ir_word", {ir_instr, ir_pc, ir_err},
                {instr_of(exp_pc), exp_pc,
                 err_en && (exp_pc == err_addr)});
            ir_log.push_back(ir_pc);
            if (ir_err) begin
                saw_err = 1'b1;
                err_pc  = ir_pc;
            end
            exp_pc += 32'd4;
            n_ir++;
        end
        if (halted) chk("halt_noreq", mem.ifu_req_valid, 0);
        if (hs) begin
            chk("req_addr", mem.ifu_req_addr, req_exp);
            chk("credit", mq_addr.size() < QD, 1);
            mq_addr.push_back(mem.ifu_req_addr);
            mq_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
            mq_ep.push_back(epoch);
            req_exp += 32'd4;
            n_req++;
        end
        if (mem.ifu_rsp_valid) begin
            if (mq_ep[0] == epoch && mem.ifu_rsp_err && !redirect_valid)
                halted = 1'b1;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            void'(mq_ep.pop_front());
        end
        after_redir = redirect_valid;
        if (redirect_valid) begin
            epoch++;
            exp_pc    = redir_tgt & ~32'h3;
            req_exp   = exp_pc;
            after_tgt = exp_pc;
            halted    = 1'b0;
        end
        redir_req = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_ir(input int target, input int budget,
                                input string name);
        int k = 0;
        while (n_ir < target && k < budget) begin
            cycle();
            k++;
        end
        chk(name, n_ir >= target, 1);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_req = 1'b1;
        redir_tgt = tgt;
        cycle();
        ir_log.delete();
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (ir_log.size() > i) ? ir_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, k;
        tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
        tbl[4] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044};

        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
        mem.ifu_req_ready = 1'b0; mem.ifu_rsp_valid = 1'b0;
        mem.ifu_rsp_instr = '0; mem.ifu_rsp_err = 1'b0;
        redir_req = 1'b0; redir_tgt = '0; err_en = 1'b0; err_addr = '0;
        p_rdy = 100; p_ir = 100; lat_lo = 1; lat_hi = 1;
        cyc = 0; epoch = 0; exp_pc = 32'h0; req_exp = 32'h0;
        after_tgt = '0; halted = 1'b0; after_redir = 1'b0;
        n_ir = 0; n_req = 0; saw_err = 1'b0; err_pc = '0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", mem.ifu_req_valid, 0);
        chk("rst_req_addr", mem.ifu_req_addr, 32'h0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir_err", ir_err, 0);
        chk("rst_ir_instr", ir_instr, 0);
        chk("rst_ir_pc", ir_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first request on the 2nd edge, then full-rate streaming
        cycle();
        chk("first_req_wait", s_req_valid, 0);
        cycle();
        chk("first_req", s_req_valid, 1);
        chk("first_addr", s_req_addr, 32'h0);
        repeat (4) cycle();
        chk("first_ir_pc", log_at(0), 32'h0);
        base = n_ir;
        repeat (8) cycle();
        chk("throughput", n_ir - base, 8);

        // decode backpressure
        p_ir = 0;
        repeat (5) cycle();
        chk("bp_noreq", s_req_valid, 0);
        chk("bp_inflight", n_req - n_ir, QD);
        chk("bp_valid", s_ir_valid, 1);
        chk("bp_pc", s_ir_pc, exp_pc);
        p_ir = 100;
        base = n_ir;
        repeat (6) cycle();
        chk("bp_resume", n_ir - base, 6);

        // redirect with two requests outstanding
        lat_lo = 3; lat_hi = 3;
        k = 0;
        while (mq_addr.size() != 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("pre_out2", mq_addr.size(), 2);
        redirect_to(32'h0000_0103);
        base = n_ir;
        run_until_ir(base + 1, 30, "r103_wait");
        chk("r103_pc", log_at(0), 32'h100);

        // bus error halts, redirect resumes
        lat_lo = 1; lat_hi = 1;
        err_en = 1'b1; err_addr = 32'h8;
        saw_err = 1'b0;
        redirect_to(32'h0);
        k = 0;
        while (!saw_err && k < 30) begin
            cycle();
            k++;
        end
        chk("err_seen", saw_err, 1);
        chk("err_pc", err_pc, 32'h8);
        repeat (5) cycle();
        chk("halt_req", s_req_valid, 0);
        redirect_to(32'h40);
        base = n_ir;
        run_until_ir(base + 1, 30, "resume_wait");
        chk("resume_pc", log_at(0), 32'h40);
        repeat (4) cycle();
        err_en = 1'b0;

        // redirect table, including wrap past 0xFFFF_FFFC
        for (int i = 0; i < 5; i++) begin
            redirect_to(tbl[i].tgt);
            base = n_ir;
            cycle();
            chk("tbl_addr", s_req_addr, tbl[i].pc0);
            run_until_ir(base + 2, 20, "tbl_wait");
            chk("tbl_pc0", log_at(0), tbl[i].pc0);
            chk("tbl_pc1", log_at(1), tbl[i].pc1);
        end

        // redirect together with a response, request and ir pop
        repeat (4) cycle();
        redirect_to(32'h200);
        chk("sim_rsp", s_rsp, 1);
        chk("sim_hs", s_hs, 1);
        base = n_ir;
        run_until_ir(base + 3, 20, "sim_wait");
        chk("sim_pc0", log_at(0), 32'h200);
        chk("sim_pc2", log_at(2), 32'h208);

        // randomized run against the stream model
        p_rdy = 70; p_ir = 65; lat_lo = 1; lat_hi = 3;
        err_en = 1'b1; err_addr = 32'h24;
        base = n_ir;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < (halted ? 15 : 3)) begin
                redir_req = 1'b1;
                if ($urandom_range(3) == 0)
                    redir_tgt = 32'hFFFF_FFF0 + $urandom_range(15);
                else
                    redir_tgt = $urandom_range(63);
            end
            cycle();
        end
        chk("rand_progress", (n_ir - base) > 300, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
